// File: rtl/oddr_seq_pkg.sv
// Shared types and defaults for the O_DDR transmit sequencer.
package oddr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    GAP      = 2'd3
  } state_t;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_PRE_LEN = 4;
  localparam int DEF_GAP_LEN = 2;

  localparam logic [1:0] PREAMBLE_PAIR = 2'b10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/oddr_pair_shifter.sv
// Word-to-pair serializer: parallel load, 2-bit right shift, pair index and
// a flag marking the cycle in which the last pair of the word is on the wire.
module oddr_pair_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [1:0]        next_pair_o,
  output logic              last_o
);

  localparam int NPAIRS = DATA_W / 2;
  localparam int PCNT_W = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
  localparam logic [PCNT_W-1:0] LAST_IDX = PCNT_W'(NPAIRS - 1);

  // sr_q holds only the pairs not yet driven; pair 0 goes out directly on load.
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;

  always_comb begin
    sr_d   = sr_q;
    pcnt_d = pcnt_q;
    if (load_i) begin
      sr_d   = data_i >> 2;
      pcnt_d = '0;
    end else if (shift_i) begin
      sr_d   = sr_q >> 2;
      pcnt_d = pcnt_q + PCNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q   <= '0;
      pcnt_q <= '0;
    end else begin
      sr_q   <= sr_d;
      pcnt_q <= pcnt_d;
    end
  end

  assign next_pair_o = sr_q[1:0];
  assign last_o      = (pcnt_q == LAST_IDX);

endmodule

// File: rtl/oddr_tx_sequencer.sv
// Frame sequencer feeding an external O_DDR: preamble, serialized data pairs,
// then an inter-frame gap, with done/underrun pulses.
module oddr_tx_sequencer
  import oddr_seq_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PRE_LEN = DEF_PRE_LEN,
  parameter int GAP_LEN = DEF_GAP_LEN
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  input  logic              TX_LAST,
  output logic              TX_READY,
  output logic [1:0]        DDR_D,
  output logic              DDR_E,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              UNDERRUN,
  output logic [1:0]        DBG_STATE
);

  localparam int CNT_MAX = max_int(PRE_LEN, GAP_LEN);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_word_q, last_word_d;
  logic [1:0]       ddr_d_q, ddr_d_d;
  logic             ddr_e_q, ddr_e_d;
  logic             done_q, done_d;
  logic             urun_q, urun_d;
  logic             load, shift;
  logic [1:0]       sh_pair;
  logic             sh_last;

  oddr_pair_shifter #(.DATA_W(DATA_W)) u_shifter (
    .clk_i       (CLK),
    .rst_i       (RST),
    .load_i      (load),
    .shift_i     (shift),
    .data_i      (TX_DATA),
    .next_pair_o (sh_pair),
    .last_o      (sh_last)
  );

  // Handshake: a word moves when TX_VALID and TX_READY are both high at the
  // edge; TX_READY depends on state/counters only, so it never waits on valid.
  assign TX_READY = ((state_q == PREAMBLE) && (cnt_q == PRE_LAST)) ||
                    ((state_q == DATA) && sh_last && !last_word_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_word_d = last_word_q;
    ddr_d_d     = 2'b00;
    ddr_e_d     = 1'b0;
    done_d      = 1'b0;
    urun_d      = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
    case (state_q)
      IDLE: begin
        if (TX_VALID) begin
          state_d = PREAMBLE;
          cnt_d   = '0;
          ddr_d_d = PREAMBLE_PAIR;
          ddr_e_d = 1'b1;
        end
      end
      PREAMBLE: begin
        if (cnt_q != PRE_LAST) begin
          cnt_d   = cnt_q + CNT_W'(1);
          ddr_d_d = PREAMBLE_PAIR;
          ddr_e_d = 1'b1;
        end else if (TX_VALID) begin
          state_d     = DATA;
          load        = 1'b1;
          last_word_d = TX_LAST;
          ddr_d_d     = TX_DATA[1:0];
          ddr_e_d     = 1'b1;
        end else begin
          state_d = GAP;
          cnt_d   = '0;
          urun_d  = 1'b1;
        end
      end
      DATA: begin
        if (!sh_last) begin
          shift   = 1'b1;
          ddr_d_d = sh_pair;
          ddr_e_d = 1'b1;
        end else if (last_word_q) begin
          state_d = GAP;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else if (TX_VALID) begin
          load        = 1'b1;
          last_word_d = TX_LAST;
          ddr_d_d     = TX_DATA[1:0];
          ddr_e_d     = 1'b1;
        end else begin
          state_d = GAP;
          cnt_d   = '0;
          urun_d  = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_word_q <= 1'b0;
      ddr_d_q     <= 2'b00;
      ddr_e_q     <= 1'b0;
      done_q      <= 1'b0;
      urun_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_word_q <= last_word_d;
      ddr_d_q     <= ddr_d_d;
      ddr_e_q     <= ddr_e_d;
      done_q      <= done_d;
      urun_q      <= urun_d;
    end
  end

  assign DDR_D      = ddr_d_q;
  assign DDR_E      = ddr_e_q;
  assign FRAME_DONE = done_q;
  assign UNDERRUN   = urun_q;
  assign BUSY       = (state_q != IDLE);
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_oddr_tx_sequencer.sv
// Bench for oddr_tx_sequencer: directed and random frames checked cycle by
// cycle against a frame-level model of the wire behaviour.
module tb_oddr_tx_sequencer;

  localparam int DATA_W  = 8;
  localparam int PRE_LEN = 4;
  localparam int GAP_LEN = 2;
  localparam int NPAIRS  = DATA_W / 2;

  logic              CLK = 1'b0;
  logic              RST;
  logic [DATA_W-1:0] TX_DATA;
  logic              TX_VALID;
  logic              TX_LAST;
  logic              TX_READY;
  logic [1:0]        DDR_D;
  logic              DDR_E;
  logic              BUSY;
  logic              FRAME_DONE;
  logic              UNDERRUN;
  logic [1:0]        DBG_STATE;

  int tests = 0;
  int fails = 0;

  // Entry layout: {ready, busy, ddr_e, ddr_d[1:0], frame_done, underrun}
  logic [6:0]        exp_q[$];
  logic [DATA_W-1:0] words[$];

  oddr_tx_sequencer #(
    .DATA_W (DATA_W),
    .PRE_LEN(PRE_LEN),
    .GAP_LEN(GAP_LEN)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .TX_DATA   (TX_DATA),
    .TX_VALID  (TX_VALID),
    .TX_LAST   (TX_LAST),
    .TX_READY  (TX_READY),
    .DDR_D     (DDR_D),
    .DDR_E     (DDR_E),
    .BUSY      (BUSY),
    .FRAME_DONE(FRAME_DONE),
    .UNDERRUN  (UNDERRUN),
    .DBG_STATE (DBG_STATE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] ent(input logic rdy, input logic busy, input logic e,
                                     input logic [1:0] d, input logic done, input logic urun);
    return {rdy, busy, e, d, done, urun};
  endfunction

  function automatic logic [6:0] observe();
    return {TX_READY, BUSY, DDR_E, DDR_D, FRAME_DONE, UNDERRUN};
  endfunction

  // Expected wire trace of one frame, starting with the first preamble cycle.
  task automatic build_exp(input bit end_last, input int rst_at);
    int n;
    logic [DATA_W-1:0] sh;
    n = words.size();
    exp_q.delete();
    for (int i = 0; i < PRE_LEN; i++)
      exp_q.push_back(ent(i == PRE_LEN - 1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0));
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < NPAIRS; k++) begin
        sh = words[w] >> (2 * k);
        exp_q.push_back(ent((k == NPAIRS - 1) && !(w == n - 1 && end_last),
                            1'b1, 1'b1, sh[1:0], 1'b0, 1'b0));
      end
    end
    for (int g = 0; g < GAP_LEN; g++)
      exp_q.push_back(ent(1'b0, 1'b1, 1'b0, 2'b00, (g == 0) && end_last, (g == 0) && !end_last));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    if (rst_at >= 0) begin
      while (exp_q.size() > rst_at + 1) void'(exp_q.pop_back());
      exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
      exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    end
  endtask

  // Drives the frame held in words[] starting from IDLE; garbage is placed on
  // TX_DATA/TX_LAST whenever no transfer can happen.
  task automatic run_frame(input string name, input bit end_last, input bit hold, input int rst_at);
    int wi;
    int idx;
    bit stopped;
    logic [6:0] obs;
    logic [6:0] expv;
    wi = 0;
    idx = 0;
    stopped = 1'b0;
    build_exp(end_last, rst_at);
    TX_VALID = 1'b1;
    TX_DATA  = DATA_W'($urandom);
    TX_LAST  = 1'($urandom_range(0, 1));
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      obs  = observe();
      expv = exp_q.pop_front();
      tests++;
      assert (obs === expv) else begin
        fails++;
        $error("FAIL %s cyc %0d: got rdy/busy/e/d/done/urun=%b expected %b", name, idx, obs, expv);
      end
      if (exp_q.size() == 0) break;
      TX_DATA = DATA_W'($urandom);
      TX_LAST = 1'($urandom_range(0, 1));
      if (idx == rst_at) begin
        RST      = 1'b1;
        TX_VALID = 1'b0;
        stopped  = 1'b1;
      end else begin
        RST = 1'b0;
        if (stopped) begin
          TX_VALID = 1'b0;
        end else if (TX_READY) begin
          TX_VALID = (wi < words.size());
          if (TX_VALID) begin
            TX_DATA = words[wi];
            TX_LAST = end_last && (wi == words.size() - 1);
            wi++;
          end
        end else begin
          TX_VALID = hold ? 1'b1 : 1'($urandom_range(0, 1));
        end
      end
      idx++;
    end
    if (!hold) TX_VALID = 1'b0;
  endtask

  initial begin
    int n;
    bit el;
    bit hd;
    logic [6:0] obs;

    RST      = 1'b1;
    TX_VALID = 1'b0;
    TX_LAST  = 1'b0;
    TX_DATA  = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    obs = observe();
    tests++;
    assert (obs === 7'b0) else begin
      fails++;
      $error("FAIL reset_state: got %b expected %b", obs, 7'b0);
    end
    RST = 1'b0;
    @(negedge CLK);
    obs = observe();
    tests++;
    assert (obs === 7'b0) else begin
      fails++;
      $error("FAIL idle_after_reset: got %b expected %b", obs, 7'b0);
    end

    words = '{8'hB4};
    run_frame("single_b4", 1'b1, 1'b0, -1);

    words = '{8'h1B, 8'hE4};
    run_frame("two_words", 1'b1, 1'b0, -1);

    words = '{8'hFF};
    run_frame("underrun_ff", 1'b0, 1'b0, -1);

    words.delete();
    run_frame("preamble_only", 1'b0, 1'b0, -1);

    words = '{8'hB4};
    run_frame("reset_mid", 1'b1, 1'b0, PRE_LEN + 1);
    run_frame("after_reset", 1'b1, 1'b0, -1);

    words = '{8'h5A};
    run_frame("hold_in_gap", 1'b1, 1'b1, -1);
    words = '{8'hC3, 8'h96};
    run_frame("after_hold", 1'b1, 1'b0, -1);

    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(0, 3);
      words.delete();
      for (int w = 0; w < n; w++) words.push_back(DATA_W'($urandom));
      el = (n > 0) && ($urandom_range(0, 1) == 1);
      hd = el && ($urandom_range(0, 1) == 1);
      run_frame($sformatf("rand%0d", f), el, hd, -1);
    end
    TX_VALID = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oddr_tx_sequencer.md
ODDR_TX_SEQUENCER -- requirements
Module: oddr_tx_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits; SHALL be even and >= 4.
REQ-002 Parameter PRE_LEN, default 4, preamble length in cycles; SHALL be >= 1.
REQ-003 Parameter GAP_LEN, default 2, inter-frame gap length in cycles; SHALL be >= 1.
REQ-004 CLK  input  1  single clock; all logic on posedge CLK.
REQ-005 RST  input  1  reset; synchronous, active-high.
REQ-006 TX_DATA  input  DATA_W  word to serialize, LSB pair first.
REQ-007 TX_VALID  input  1  TX_DATA/TX_LAST valid.
REQ-008 TX_LAST  input  1  current word is the final word of the frame.
REQ-009 TX_READY  output  1  sequencer accepts the word this cycle.
REQ-010 DDR_D  output  2  bit pair to the O_DDR D port; DDR_D[0] is the earlier bit.
REQ-011 DDR_E  output  1  O_DDR enable; high while a frame is driven.
REQ-012 BUSY  output  1  high in any state other than IDLE.
REQ-013 FRAME_DONE  output  1  one-cycle pulse on normal frame completion.
REQ-014 UNDERRUN  output  1  one-cycle pulse when a frame is aborted for lack of data.

Function
REQ-015 The FSM SHALL have states IDLE, PREAMBLE, DATA and GAP.
REQ-016 A transfer SHALL occur only on a cycle with TX_VALID and TX_READY both high.
REQ-017 DDR_D, DDR_E, FRAME_DONE and UNDERRUN SHALL be registered outputs; TX_READY SHALL be combinational from state and counters only, never from TX_VALID.
REQ-018 IDLE: DDR_D=00, DDR_E=0, TX_READY=0; TX_VALID high SHALL move the FSM to PREAMBLE on the next edge without consuming the word.
REQ-019 PREAMBLE: DDR_D=10, DDR_E=1 for exactly PRE_LEN cycles; TX_READY SHALL be high only in the last preamble cycle.
REQ-020 A word accepted in cycle t SHALL drive pair k (TX_DATA[2k+1:2k]) on DDR_D in cycle t+1+k, for k = 0..DATA_W/2-1, with DDR_E=1.
REQ-021 DATA: TX_READY SHALL be high only in the cycle in which the last pair of the current word is on DDR_D, so back-to-back words stream with no bubble.
REQ-022 If the word with TX_LAST is accepted, the FSM SHALL enter GAP after its last pair, and FRAME_DONE SHALL pulse in the first GAP cycle.
REQ-023 If TX_READY is high in DATA or PREAMBLE and TX_VALID is low, the FSM SHALL enter GAP on the next edge and UNDERRUN SHALL pulse in the first GAP cycle; FRAME_DONE SHALL stay low.
REQ-024 An underrun in the last preamble cycle SHALL be treated like REQ-023, so the frame contains a preamble only.
REQ-025 GAP: DDR_D=00, DDR_E=0, TX_READY=0 for exactly GAP_LEN cycles, then IDLE; TX_VALID during GAP SHALL be ignored.
REQ-026 The pair counter SHALL be $clog2(DATA_W/2) bits wide and wrap from DATA_W/2-1 to 0 on every accepted word.
REQ-027 The preamble and gap counters SHALL be sized to max(PRE_LEN, GAP_LEN) and SHALL never overflow.
REQ-028 TX_DATA and TX_LAST SHALL be sampled only on a transfer; changes at other times SHALL have no effect.

Reset
REQ-029 RST high at a clock edge SHALL force IDLE, clear all counters and the shift register, and set DDR_D=00, DDR_E=0, BUSY=0, FRAME_DONE=0, UNDERRUN=0, with TX_READY=0 after that edge.
REQ-030 RST asserted mid-frame SHALL abort the frame with no FRAME_DONE or UNDERRUN pulse; no residual pair SHALL be driven after reset is released.

Structure
REQ-031 Package oddr_seq_pkg SHALL hold the state enum type and the default DATA_W, PRE_LEN, GAP_LEN and PREAMBLE_PAIR (2'b10) constants.
REQ-032 One sub-module, oddr_pair_shifter (parallel load, 2-bit right shift, pair count, last-pair flag), SHALL implement the data path; the FSM stays in oddr_tx_sequencer.
REQ-033 The O_DDR primitive SHALL be instantiated outside this block, with DDR_D on D, DDR_E on E, CLK on C and 1'b0 on R.

Verification
REQ-034 Single word 8'hB4 with TX_LAST, defaults -> 4 cycles DDR_D=10, then 00,01,11,10 with DDR_E=1, FRAME_DONE pulse, 2 cycles of DDR_E=0, BUSY low.
REQ-035 Two words 8'h1B then 8'hE4 (last), held valid -> DDR_D 11,10,01,00,00,01,10,11 contiguous, TX_READY high exactly twice.
REQ-036 Word 8'hFF without TX_LAST, then TX_VALID low -> pairs 11 x4, UNDERRUN pulse, no FRAME_DONE, GAP then IDLE.
REQ-037 TX_VALID dropped in the last preamble cycle -> preamble only, UNDERRUN pulse, DDR_E low for GAP_LEN cycles.
REQ-038 RST for 1 cycle at the 2nd data pair of 8'hB4 -> next cycle DDR_D=00, DDR_E=0, BUSY=0, no pulses; a new frame afterward is correct.
REQ-039 TX_VALID held high during GAP -> no transfer until after IDLE, then a fresh PRE_LEN preamble.
